pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Drives write-enable, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers and the PC.
- Detects load-use hazards and acts on EX-stage redirects (branch taken, jal, jalr).
- Freezes the whole pipeline while a multi-cycle data-memory access in the MEM stage completes.

Parameters:
- MEM_LATENCY, 2, data-memory access time in cycles (legal 1..16); pipeline frozen MEM_LATENCY-1 cycles per access.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of instruction in IF/ID
- id_rs2  in  5  rs2 of instruction in IF/ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_memread  in  1  MemRead of ID/EX register
- ex_rd  in  5  rd of ID/EX register
- ex_redirect  in  1  EX resolved taken branch / Jump / Jalr
- mem_access  in  1  MemRead|MemWrite of EX/MEM register
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_write  out  1  ID/EX load enable
- id_ex_flush  out  1  ID/EX clear (controls zeroed = bubble)
- ex_mem_write  out  1  EX/MEM load enable
- mem_wb_bubble  out  1  load MEM/WB with RegWrite=0 bubble
- ctrl_state  out  2  FSM state: RUN=0, MEM_WAIT=1, MEM_DONE=2

Behaviour:
- State registers:
  - FSM state; wait counter cnt, width $clog2(MEM_LATENCY)+1.
  - Both update on rising clk; reset=1 at an edge -> state RUN, cnt=0, regardless of current state (abandons a wait mid-operation).
- Outputs are combinational from state and inputs, zero added latency.
- While reset=1, outputs forced to defaults.
- Defaults: all *_write=1, all flushes=0, mem_wb_bubble=0.
- Freeze: pc_write=if_id_write=id_ex_write=ex_mem_write=0, mem_wb_bubble=1, flushes=0.
- Load-use hazard (LU): ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - x0 never hazards.
- RUN:
  - If mem_access & MEM_LATENCY>1: freeze; cnt<=MEM_LATENCY-2; next = MEM_DONE if MEM_LATENCY==2, else MEM_WAIT. LU and ex_redirect ignored this cycle.
  - Else if ex_redirect: pc_write=1, if_id_flush=1, id_ex_flush=1. LU suppressed, since the hazarding instruction is being flushed.
  - Else if LU: pc_write=0, if_id_write=0, id_ex_flush=1, others default. This is a one-cycle bubble; it clears naturally next cycle.
  - MEM_LATENCY==1: mem_access has no effect; FSM never leaves RUN.
- MEM_WAIT:
  - Freeze; cnt<=cnt-1.
  - When cnt==1, next=MEM_DONE; else stay.
  - Inputs are held stable by the frozen registers; ex_redirect/LU not acted on.
- MEM_DONE:
  - Release cycle; same output rules as RUN except mem_access ignored (same access still in EX/MEM).
  - Pending redirect/LU handled here.
  - next=RUN.
- Frozen cycles per access = MEM_LATENCY-1 exactly.
- Back-to-back memory ops: the second is seen in RUN the cycle after MEM_DONE and starts a new wait.
- Simultaneous priority: reset > memory freeze > redirect > load-use.
- No X on any output when inputs are known.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds out ports stall_cycles[31:0] and flush_events[31:0], reset to 0.
  - stall_cycles +1 each cycle pc_write==0 (LU bubbles and freezes).
  - flush_events +1 each cycle if_id_flush==1.
  - Both saturate at 32'hFFFF_FFFF; neither counts while reset=1.
- Undefined: same ports present, tied to 0; no counter flops.

Test Plan:
- MEM_LATENCY=2; ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle. Repeat with ex_rd=0 -> no stall.
- Same LU plus ex_redirect=1 same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1 (redirect wins).
- MEM_LATENCY=4; mem_access=1 held 4 cycles:
  - ctrl_state 0,1,1,2.
  - Freeze outputs in the first 3 cycles, mem_wb_bubble=1.
  - 4th cycle defaults; then back to 0.
- MEM_LATENCY=3; ex_redirect=1 held through the access -> no flush during 2 frozen cycles; flush asserted in the MEM_DONE cycle.
- MEM_LATENCY=4; reset=1 pulsed in the second MEM_WAIT cycle -> next cycle ctrl_state=0 and outputs at defaults.
- HAZARD_PERF_CNT_EN defined, MEM_LATENCY=3: one access + one LU + one redirect -> stall_cycles=3, flush_events=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_memread;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       mem_access;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_write;
    logic       id_ex_flush;
    logic       ex_mem_write;
    logic       mem_wb_bubble;
    logic [1:0] ctrl_state;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_memread, ex_rd, ex_redirect, mem_access,
        input  pc_write, if_id_write, if_id_flush, id_ex_write,
               id_ex_flush, ex_mem_write, mem_wb_bubble, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_memread, ex_rd, ex_redirect, mem_access,
        output pc_write, if_id_write, if_id_flush, id_ex_write,
               id_ex_flush, ex_mem_write, mem_wb_bubble, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles,
// EX redirects, and whole-pipe freeze for multi-cycle data-memory accesses.
// Optional macro HAZARD_PERF_CNT_EN enables the stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int MEM_LATENCY = 2
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz,
    output logic [31:0]        stall_cycles,
    output logic [31:0]        flush_events
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } state_t;

    localparam int              CW         = $clog2(MEM_LATENCY) + 1;
    localparam bit              MEM_MULTI  = (MEM_LATENCY > 1);
    localparam logic [CW-1:0]   CNT_INIT   = MEM_MULTI ? CW'(MEM_LATENCY - 2) : '0;
    localparam state_t          FIRST_WAIT = (MEM_LATENCY == 2) ? MEM_DONE : MEM_WAIT;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic            freeze, steer, load_use;
    logic            pc_write, if_id_write, if_id_flush;
    logic            id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble;

    logic [4:0]      src_reg [2];
    logic [1:0]      src_use;
    logic [1:0]      src_hit;

    assign src_reg[0] = hz.id_rs1;
    assign src_reg[1] = hz.id_rs2;
    assign src_use    = {hz.id_uses_rs2, hz.id_uses_rs1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_reg[gi] == hz.ex_rd);
        end
    endgenerate

    // x0 is hardwired to zero, so a load targeting it can never hazard.
    assign load_use = hz.ex_memread && (hz.ex_rd != 5'd0) && (|src_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        freeze        = 1'b0;
        steer         = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_write  = 1'b1;
        mem_wb_bubble = 1'b0;

        if (!reset) begin
            case (state_reg)
                RUN: begin
                    if (hz.mem_access && MEM_MULTI) begin
                        freeze     = 1'b1;
                        cnt_next   = CNT_INIT;
                        state_next = FIRST_WAIT;
                    end else begin
                        steer = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    freeze   = 1'b1;
                    cnt_next = cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        state_next = MEM_DONE;
                    end
                end
                // Release cycle: the finished access still sits in EX/MEM, so
                // mem_access is ignored but pending redirect/load-use act now.
                MEM_DONE: begin
                    steer      = 1'b1;
                    state_next = RUN;
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end

        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else if (steer && hz.ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (steer && load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign hz.pc_write      = pc_write;
    assign hz.if_id_write   = if_id_write;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.id_ex_write   = id_ex_write;
    assign hz.id_ex_flush   = id_ex_flush;
    assign hz.ex_mem_write  = ex_mem_write;
    assign hz.mem_wb_bubble = mem_wb_bubble;
    assign hz.ctrl_state    = state_reg;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_reg, flush_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_reg <= '0;
            flush_reg <= '0;
        end else begin
            if (!pc_write && (stall_reg != 32'hFFFF_FFFF)) begin
                stall_reg <= stall_reg + 32'd1;
            end
            if (if_id_flush && (flush_reg != 32'hFFFF_FFFF)) begin
                flush_reg <= flush_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_reg;
    assign flush_events = flush_reg;
`else
    assign stall_cycles = 32'd0;
    assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: four instances with MEM_LATENCY 1..4
// share the stimulus; each has its own reset so sequences stay independent.
module tb_pipe_hazard_ctrl;
    // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_write,
    //                       id_ex_flush, ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] DEF    = 7'b1101010;
    localparam logic [6:0] LU     = 7'b0001110;
    localparam logic [6:0] REDIR  = 7'b1111110;
    localparam logic [6:0] FREEZE = 7'b0000001;

    logic        clk = 1'b0;
    logic [3:0]  rst;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, mr, redir, mem;

    logic [6:0]  outv  [4];
    logic [1:0]  stv   [4];
    logic [31:0] stall [4];
    logic [31:0] flush [4];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hzi [4] ();

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            assign hzi[gi].id_rs1      = rs1;
            assign hzi[gi].id_rs2      = rs2;
            assign hzi[gi].id_uses_rs1 = u1;
            assign hzi[gi].id_uses_rs2 = u2;
            assign hzi[gi].ex_memread  = mr;
            assign hzi[gi].ex_rd       = rd;
            assign hzi[gi].ex_redirect = redir;
            assign hzi[gi].mem_access  = mem;
            assign outv[gi] = {hzi[gi].pc_write, hzi[gi].if_id_write, hzi[gi].if_id_flush,
                               hzi[gi].id_ex_write, hzi[gi].id_ex_flush, hzi[gi].ex_mem_write,
                               hzi[gi].mem_wb_bubble};
            assign stv[gi] = hzi[gi].ctrl_state;

            pipe_hazard_ctrl #(.MEM_LATENCY(gi + 1)) u_dut (
                .clk          (clk),
                .reset        (rst[gi]),
                .hz           (hzi[gi]),
                .stall_cycles (stall[gi]),
                .flush_events (flush[gi])
            );
        end
    endgenerate

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       redir;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // d is the instance index (MEM_LATENCY - 1).
    task automatic ck(input string nm, input int d, input logic [6:0] eo, input logic [1:0] es);
        chk({nm, "_out"}, {25'd0, outv[d]}, {25'd0, eo});
        chk({nm, "_state"}, {30'd0, stv[d]}, {30'd0, es});
    endtask

    task automatic clr_in();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        u1 = 1'b0; u2 = 1'b0; mr = 1'b0; redir = 1'b0; mem = 1'b0;
    endtask

    task automatic set_lu();
        rs1 = 5'd5; u1 = 1'b1; mr = 1'b1; rd = 5'd5;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Reset every instance with hazard inputs applied: outputs must stay at defaults.
    task automatic reset_all();
        rst = 4'hF;
        set_lu();
        redir = 1'b1;
        mem   = 1'b1;
        @(negedge clk);
        chk("rst_hold_l2_out", {25'd0, outv[1]}, {25'd0, DEF});
        chk("rst_hold_l4_out", {25'd0, outv[3]}, {25'd0, DEF});
        next_cyc();
        rst = 4'h0;
        clr_in();
        @(negedge clk);
        ck("rst_release_l2", 1, DEF, 2'd0);
        next_cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        //           rs1    rs2   u1 u2 mr  rd    redir exp
        vecs[0] = '{5'd5,  5'd0, 1, 0, 1, 5'd5,  0,    LU};
        vecs[1] = '{5'd0,  5'd0, 1, 0, 1, 5'd0,  0,    DEF};
        vecs[2] = '{5'd1,  5'd9, 1, 1, 1, 5'd9,  0,    LU};
        vecs[3] = '{5'd5,  5'd0, 0, 0, 1, 5'd5,  0,    DEF};
        vecs[4] = '{5'd5,  5'd0, 1, 0, 0, 5'd5,  0,    DEF};
        vecs[5] = '{5'd4,  5'd3, 1, 1, 1, 5'd5,  0,    DEF};
        vecs[6] = '{5'd5,  5'd0, 1, 0, 1, 5'd5,  1,    REDIR};
        vecs[7] = '{5'd0,  5'd0, 0, 0, 0, 5'd0,  1,    REDIR};
        vecs[8] = '{5'd31, 5'd0, 0, 1, 1, 5'd31, 0,    DEF};

        rst = 4'hF;
        clr_in();
        next_cyc();
        reset_all();

        // Single-cycle vectors on MEM_LATENCY=2 in RUN.
        for (int i = 0; i < 9; i++) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; u1 = vecs[i].u1; u2 = vecs[i].u2;
            mr = vecs[i].mr; rd = vecs[i].rd; redir = vecs[i].redir; mem = 1'b0;
            @(negedge clk);
            ck($sformatf("vec%0d", i), 1, vecs[i].exp, 2'd0);
            next_cyc();
        end
        clr_in();

        // MEM_LATENCY=4, access held 4 cycles: states 0,1,1,2 then back to 0.
        reset_all();
        mem = 1'b1;
        @(negedge clk); ck("l4_c1", 3, FREEZE, 2'd0); next_cyc();
        @(negedge clk); ck("l4_c2", 3, FREEZE, 2'd1); next_cyc();
        @(negedge clk); ck("l4_c3", 3, FREEZE, 2'd1); next_cyc();
        @(negedge clk); ck("l4_c4", 3, DEF,    2'd2); next_cyc();
        mem = 1'b0;
        @(negedge clk); ck("l4_c5", 3, DEF,    2'd0); next_cyc();

        // MEM_LATENCY=3, redirect held through the access: flush only on release.
        reset_all();
        mem = 1'b1; redir = 1'b1;
        @(negedge clk); ck("l3_redir_c1", 2, FREEZE, 2'd0); next_cyc();
        @(negedge clk); ck("l3_redir_c2", 2, FREEZE, 2'd1); next_cyc();
        @(negedge clk); ck("l3_redir_c3", 2, REDIR,  2'd2); next_cyc();
        clr_in();
        @(negedge clk); ck("l3_redir_c4", 2, DEF,    2'd0); next_cyc();

        // MEM_LATENCY=4, reset pulsed during the second MEM_WAIT cycle.
        reset_all();
        mem = 1'b1;
        @(negedge clk); ck("l4_rst_c1", 3, FREEZE, 2'd0); next_cyc();
        @(negedge clk); ck("l4_rst_c2", 3, FREEZE, 2'd1); next_cyc();
        rst[3] = 1'b1;
        @(negedge clk); chk("l4_rst_c3_out", {25'd0, outv[3]}, {25'd0, DEF}); next_cyc();
        rst[3] = 1'b0; mem = 1'b0;
        @(negedge clk); ck("l4_rst_c4", 3, DEF, 2'd0); next_cyc();

        // MEM_LATENCY=2, back-to-back accesses with a pending load-use.
        reset_all();
        mem = 1'b1; set_lu();
        @(negedge clk); ck("l2_b2b_c1", 1, FREEZE, 2'd0); next_cyc();
        @(negedge clk); ck("l2_b2b_c2", 1, LU,     2'd2); next_cyc();
        @(negedge clk); ck("l2_b2b_c3", 1, FREEZE, 2'd0); next_cyc();
        @(negedge clk); ck("l2_b2b_c4", 1, LU,     2'd2); next_cyc();
        clr_in();
        @(negedge clk); ck("l2_b2b_c5", 1, DEF,    2'd0); next_cyc();

        // MEM_LATENCY=1: mem_access never freezes.
        reset_all();
        mem = 1'b1;
        @(negedge clk); ck("l1_c1", 0, DEF, 2'd0); next_cyc();
        set_lu();
        @(negedge clk); ck("l1_c2", 0, LU,  2'd0); next_cyc();
        clr_in();

        // Performance counters on MEM_LATENCY=3: one access, one LU, one redirect.
        reset_all();
        mem = 1'b1;
        @(negedge clk); ck("perf_c1", 2, FREEZE, 2'd0); next_cyc();
        @(negedge clk); ck("perf_c2", 2, FREEZE, 2'd1); next_cyc();
        @(negedge clk); ck("perf_c3", 2, DEF,    2'd2); next_cyc();
        mem = 1'b0; set_lu();
        @(negedge clk); ck("perf_c4", 2, LU,     2'd0); next_cyc();
        clr_in(); redir = 1'b1;
        @(negedge clk); ck("perf_c5", 2, REDIR,  2'd0); next_cyc();
        clr_in();
        @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall_cycles", stall[2], 32'd3);
        chk("perf_flush_events", flush[2], 32'd1);
`else
        chk("perf_stall_cycles", stall[2], 32'd0);
        chk("perf_flush_events", flush[2], 32'd0);
`endif
        next_cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
